// File: rtl/pipeline_stall_controller.sv
// Central freeze/flush controller for the 5-stage pipeline: resolves memory
// stalls, branch flushes and hazard stalls, and keeps perf counters plus a sticky timeout flag.
module pipeline_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_Detected,
  input  logic             Branch_Taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             freeze_PC,
  output logic             freeze_IF_ID,
  output logic             flush_IF_ID,
  output logic             freeze_ID_EXE,
  output logic             flush_ID_EXE,
  output logic             freeze_EXE_MEM,
  output logic             bubble_MEM_WB,
  output logic             mem_wait,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic {
    S_RUN,
    S_MEM_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_stall;

  assign mem_stall = mem_req & ~sram_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Mealy controls; gated by rst because inputs may be active while in reset.
  always_comb begin
    freeze_PC      = 1'b0;
    freeze_IF_ID   = 1'b0;
    flush_IF_ID    = 1'b0;
    freeze_ID_EXE  = 1'b0;
    flush_ID_EXE   = 1'b0;
    freeze_EXE_MEM = 1'b0;
    bubble_MEM_WB  = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        freeze_PC      = 1'b1;
        freeze_IF_ID   = 1'b1;
        freeze_ID_EXE  = 1'b1;
        freeze_EXE_MEM = 1'b1;
        bubble_MEM_WB  = 1'b1;
      end else if (Branch_Taken) begin
        // The hazarding instruction is squashed, so the hazard is moot.
        flush_IF_ID  = 1'b1;
        flush_ID_EXE = 1'b1;
      end else if (hazard_Detected) begin
        freeze_PC    = 1'b1;
        freeze_IF_ID = 1'b1;
        flush_ID_EXE = 1'b1;
      end
    end
  end

  assign mem_wait = (state_q == S_MEM_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count     <= '0;
      flush_count     <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      if (freeze_PC && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush_IF_ID && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
      // The stall is never aborted; the flag only reports the overrun.
      if (wait_cnt_d == WAIT_MAX) mem_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two instances (default and small
// parameters) share stimulus and are checked against a rule-level model.
module tb_pipeline_stall_controller;

  localparam int A_CNT = 16;
  localparam int A_TO  = 64;
  localparam int B_CNT = 4;
  localparam int B_TO  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic hz = 1'b0, br = 1'b0, mr = 1'b0, sr = 1'b0;

  logic a_fpc, a_fifid, a_flifid, a_fidexe, a_flidexe, a_fexemem, a_bub, a_mw, a_err;
  logic b_fpc, b_fifid, b_flifid, b_fidexe, b_flidexe, b_fexemem, b_bub, b_mw, b_err;
  logic [A_CNT-1:0] a_stall, a_flush;
  logic [B_CNT-1:0] b_stall, b_flush;

  pipeline_stall_controller #(.CNT_W(A_CNT), .MEM_TIMEOUT(A_TO)) dut_a (
    .clk(clk), .rst(rst), .hazard_Detected(hz), .Branch_Taken(br),
    .mem_req(mr), .sram_ready(sr),
    .freeze_PC(a_fpc), .freeze_IF_ID(a_fifid), .flush_IF_ID(a_flifid),
    .freeze_ID_EXE(a_fidexe), .flush_ID_EXE(a_flidexe), .freeze_EXE_MEM(a_fexemem),
    .bubble_MEM_WB(a_bub), .mem_wait(a_mw), .stall_count(a_stall),
    .flush_count(a_flush), .mem_timeout_err(a_err)
  );

  pipeline_stall_controller #(.CNT_W(B_CNT), .MEM_TIMEOUT(B_TO)) dut_b (
    .clk(clk), .rst(rst), .hazard_Detected(hz), .Branch_Taken(br),
    .mem_req(mr), .sram_ready(sr),
    .freeze_PC(b_fpc), .freeze_IF_ID(b_fifid), .flush_IF_ID(b_flifid),
    .freeze_ID_EXE(b_fidexe), .flush_ID_EXE(b_flidexe), .freeze_EXE_MEM(b_fexemem),
    .bubble_MEM_WB(b_bub), .mem_wait(b_mw), .stall_count(b_stall),
    .flush_count(b_flush), .mem_timeout_err(b_err)
  );

  // {freeze_PC, freeze_IF_ID, flush_IF_ID, freeze_ID_EXE, flush_ID_EXE,
  //  freeze_EXE_MEM, bubble_MEM_WB, mem_wait}
  logic [7:0] a_ctl, b_ctl;
  assign a_ctl = {a_fpc, a_fifid, a_flifid, a_fidexe, a_flidexe, a_fexemem, a_bub, a_mw};
  assign b_ctl = {b_fpc, b_fifid, b_flifid, b_fidexe, b_flidexe, b_fexemem, b_bub, b_mw};

  int total = 0;
  int bad   = 0;

  // Model: length of the current run of stalled cycles, sticky error, counters.
  int wlen[2];
  bit merr[2];
  int scnt[2];
  int fcnt[2];
  int tmo[2]  = '{A_TO, B_TO};
  int cmax[2] = '{(1 << A_CNT) - 1, (1 << B_CNT) - 1};

  function automatic logic [7:0] exp_ctl(int i);
    logic mw;
    mw = (wlen[i] > 0);
    if (!rst)              return 8'b0;
    if (mr && !sr)         return {7'b1101011, mw};
    if (br)                return {7'b0010100, mw};
    if (hz)                return {7'b1100100, mw};
    return {7'b0, mw};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      wlen[i] = 0; merr[i] = 1'b0; scnt[i] = 0; fcnt[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [7:0] e;
    if (!rst) return;
    for (int i = 0; i < 2; i++) begin
      e = exp_ctl(i);
      if (mr && !sr) wlen[i] = wlen[i] + 1;
      else           wlen[i] = 0;
      if (wlen[i] >= tmo[i]) merr[i] = 1'b1;
      if (e[7] && scnt[i] < cmax[i]) scnt[i]++;
      if (e[5] && fcnt[i] < cmax[i]) fcnt[i]++;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0]  oc;
    logic [31:0] os, of;
    logic        oe;
    for (int i = 0; i < 2; i++) begin
      oc = (i == 0) ? a_ctl : b_ctl;
      os = (i == 0) ? 32'(a_stall) : 32'(b_stall);
      of = (i == 0) ? 32'(a_flush) : 32'(b_flush);
      oe = (i == 0) ? a_err : b_err;
      total += 4;
      if (oc !== exp_ctl(i)) begin
        bad++; $display("FAIL %s dut%0d ctl got=%b want=%b", tag, i, oc, exp_ctl(i));
      end
      if (os !== 32'(scnt[i])) begin
        bad++; $display("FAIL %s dut%0d stall_count got=%0d want=%0d", tag, i, os, scnt[i]);
      end
      if (of !== 32'(fcnt[i])) begin
        bad++; $display("FAIL %s dut%0d flush_count got=%0d want=%0d", tag, i, of, fcnt[i]);
      end
      if (oe !== merr[i]) begin
        bad++; $display("FAIL %s dut%0d timeout_err got=%b want=%b", tag, i, oe, merr[i]);
      end
    end
  endtask

  // One clock: drive, compare at negedge, advance the model at posedge.
  task automatic cycle(input logic h, input logic b, input logic m, input logic s,
                       input string tag);
    hz = h; br = b; mr = m; sr = s;
    @(negedge clk);
    compare_all(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; hz = 1'b1; br = 1'b1; mr = 1'b1; sr = 1'b1;
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    hz = 1'b0; br = 1'b0; mr = 1'b0; sr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; hz = 1'b1; br = 1'b1; mr = 1'b1; sr = 1'b1;
    model_reset();
    @(negedge clk);
    compare_all("reset_hold");
    total++;
    if (a_ctl !== 8'b0 || a_stall !== '0 || a_flush !== '0) begin
      bad++; $display("FAIL reset_zero ctl=%b stall=%0d flush=%0d want all 0", a_ctl, a_stall, a_flush);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, "reset_first");
    total++;
    if (a_stall !== 16'd1) begin
      bad++; $display("FAIL reset_first_stall stall_count got=%0d want=1", a_stall);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "hazard");
    total++;
    if (a_stall !== 16'd2) begin
      bad++; $display("FAIL hazard_stall_count got=%0d want=2", a_stall);
    end
  endtask

  task automatic test_branch();
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, "branch");
    total++;
    if (a_flush !== 16'd1 || a_stall !== 16'd0) begin
      bad++; $display("FAIL branch_counts flush=%0d stall=%0d want 1/0", a_flush, a_stall);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, "mem_wait");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, "mem_done");
    total++;
    if (a_stall !== 16'd5 || a_mw !== 1'b0) begin
      bad++; $display("FAIL mem_wait_end stall=%0d mem_wait=%b want 5/0", a_stall, a_mw);
    end
  endtask

  task automatic test_branch_masked();
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, "br_masked");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, "br_masked_done");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "br_masked_idle");
    total++;
    if (a_flush !== 16'd1) begin
      bad++; $display("FAIL br_masked_flush_count got=%0d want=1", a_flush);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, "timeout");
      total++;
      if (b_err !== (k >= B_TO)) begin
        bad++; $display("FAIL timeout_edge after %0d stalls err got=%b want=%b", k, b_err, k >= B_TO);
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, "timeout_done");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "timeout_sticky");
    total++;
    if (b_err !== 1'b1 || a_err !== 1'b0) begin
      bad++; $display("FAIL timeout_sticky b_err=%b a_err=%b want 1/0", b_err, a_err);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, "saturate");
    total++;
    if (b_stall !== 4'd15 || a_stall !== 16'd20) begin
      bad++; $display("FAIL saturate b_stall=%0d a_stall=%0d want 15/20", b_stall, a_stall);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, "mid_wait");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (a_mw !== 1'b0 || a_ctl !== 8'b0 || a_stall !== '0) begin
      bad++; $display("FAIL mid_wait_reset ctl=%b stall=%0d want 0/0", a_ctl, a_stall);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "mid_wait_after");
  endtask

  task automatic test_random();
    int burst;
    do_reset();
    burst = 0;
    for (int k = 0; k < 600; k++) begin
      logic h, b, m, s;
      if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(2, 8);
      h = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 3) == 0);
      if (burst > 0) begin
        m = 1'b1; s = 1'b0; burst--;
      end else begin
        m = $urandom_range(0, 1) == 1;
        s = $urandom_range(0, 2) != 0;
      end
      cycle(h, b, m, s, "random");
    end
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_branch();
    test_mem_wait();
    test_branch_masked();
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central freeze/flush controller for the 5-stage ARM-subset pipeline. Consumes the hazard unit's hazard_Detected, the EXE-stage Branch_Taken, and the MEM-stage SRAM ready handshake. Drives per-stage freeze and bubble/flush controls for the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. Keeps saturating performance counters and a sticky timeout error for memory accesses that never complete.

Parameters:
CNT_W, 16, width of stall_count and flush_count (saturating).
MEM_TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before mem_timeout_err sets; must be >= 2.

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
hazard_Detected  in  1  RAW hazard from hazard unit, ID stage
Branch_Taken  in  1  branch resolved taken in EXE
mem_req  in  1  MEM stage holds a load or store (MEM_R_EN | MEM_W_EN)
sram_ready  in  1  SRAM controller completes the current access this cycle
freeze_PC  out  1  hold PC
freeze_IF_ID  out  1  hold IF/ID register
flush_IF_ID  out  1  clear IF/ID register to NOP
freeze_ID_EXE  out  1  hold ID/EXE register
flush_ID_EXE  out  1  load bubble into ID/EXE
freeze_EXE_MEM  out  1  hold EXE/MEM register
bubble_MEM_WB  out  1  load bubble (WB_EN=0) into MEM/WB
mem_wait  out  1  state == S_MEM_WAIT
stall_count  out  CNT_W  cycles in which freeze_PC was 1
flush_count  out  CNT_W  branch flushes performed
mem_timeout_err  out  1  sticky; set on a MEM_WAIT timeout

Behaviour:
- States: S_RUN (reset state), S_MEM_WAIT. State, wait counter, perf counters and error flag are registered. Control outputs are combinational (Mealy) from state and inputs, so they are valid in the same cycle as the cause.
- Reset (rst=0, async): state=S_RUN, wait_cnt=0, stall_count=0, flush_count=0, mem_timeout_err=0. While rst=0 all control outputs are 0. Reset taking effect mid-wait returns to S_RUN immediately.
- Priority per cycle: memory stall > branch flush > hazard stall.
- Memory stall condition: mem_req=1 and sram_ready=0, in either state.
  - Outputs: freeze_PC, freeze_IF_ID, freeze_ID_EXE and freeze_EXE_MEM = 1; bubble_MEM_WB = 1; both flushes = 0.
  - Branch_Taken and hazard_Detected are ignored. The frozen EXE stage re-presents them after the wait.
- S_RUN to S_MEM_WAIT: when the memory stall condition holds; wait_cnt loads 1.
- In S_MEM_WAIT:
  - Each stalled cycle increments wait_cnt (saturating at MEM_TIMEOUT).
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout_err sets and stays 1 until reset. The stall continues; there is no abort.
- S_MEM_WAIT to S_RUN: the cycle sram_ready=1 or mem_req=0. No freeze is asserted in that cycle from the memory side; branch and hazard rules then apply normally. wait_cnt clears.
- Branch flush (no memory stall, Branch_Taken=1):
  - flush_IF_ID=1, flush_ID_EXE=1, all freezes 0. The PC loads the branch target.
  - hazard_Detected is ignored because the offending instruction is squashed.
  - flush_count increments by 1 (saturating).
- Hazard stall (no memory stall, no branch, hazard_Detected=1): freeze_PC=1, freeze_IF_ID=1, flush_ID_EXE=1; EXE/MEM and MEM/WB advance.
- Otherwise all control outputs are 0.
- stall_count increments in every cycle with freeze_PC=1 (memory or hazard). It saturates at 2^CNT_W-1 and does not wrap.
- mem_req=1 with sram_ready=1 in the same first cycle is a single-cycle access: no stall, no state change.
- freeze_* and flush_* on the same register are never both 1.

Test Plan:
- Reset: hold rst=0 with all inputs 1 -> all controls 0, counters 0. Release rst -> S_RUN, and the first cycle shows a memory stall (freeze_PC=1, bubble_MEM_WB=1).
- Hazard: hazard_Detected=1 for 2 cycles, other inputs 0 -> freeze_PC=freeze_IF_ID=flush_ID_EXE=1 both cycles, freeze_EXE_MEM=0, stall_count=2.
- Branch: Branch_Taken=1 together with hazard_Detected=1 for 1 cycle -> flush_IF_ID=flush_ID_EXE=1, freeze_PC=0, flush_count=1, stall_count unchanged.
- Memory wait: mem_req=1, sram_ready=0 for 5 cycles, then 1 -> mem_wait=1 for 5 cycles, all four freezes and bubble_MEM_WB=1. The 6th cycle returns to S_RUN with no freeze. stall_count=5.
- Branch masked by memory: Branch_Taken=1 throughout a 3-cycle SRAM wait -> no flush during the wait. A single flush occurs in the completion cycle; flush_count=1.
- Timeout and saturation: MEM_TIMEOUT=4, sram_ready=0 for 10 cycles -> mem_timeout_err rises on the 4th stalled cycle and remains 1 after sram_ready. Separately, with CNT_W=4 and 20 hazard cycles -> stall_count=15.
